// File: rtl/rs_syndrome_collect.sv
`default_nettype none
// ============================================================================
// Module   : rs_syndrome_collect
// Brief    : Latches final RS syndromes on each codeword's last beat and
//            forwards them to the key-equation solver through a small FIFO.
//            Optional macro RS_SYND_ZERO_BYPASS_EN drops error-free frames
//            and counts them in clean_cnt instead.
// Revision : 1.0 - initial release
// ============================================================================
module rs_syndrome_collect #(
   parameter int ROOTS_NUM  = 16,
   parameter int SYMB_WIDTH = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic                                  s_tvalid,
   input  logic                                  s_tlast,
   input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  syndrome_i,
   output logic                                  m_tvalid,
   input  logic                                  m_tready,
   output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  m_syndrome,
   output logic                                  m_err,
   output logic [15:0]                           m_frame_id,
   output logic                                  overflow,
   output logic [15:0]                           clean_cnt
);

   localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

   logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] r_mem_synd [FIFO_DEPTH];
   logic                                 r_mem_err  [FIFO_DEPTH];
   logic [15:0]                          r_mem_id   [FIFO_DEPTH];
   logic [c_PW-1:0]                      r_wr_ptr;
   logic [c_PW-1:0]                      r_rd_ptr;
   logic [c_CW-1:0]                      r_count;
   logic [15:0]                          r_frame_cnt;
   logic                                 r_overflow;

   logic w_capture;
   logic w_err;
   logic w_keep;
   logic w_store;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_capture = s_tvalid && s_tlast;
   assign w_err     = |syndrome_i;
`ifdef RS_SYND_ZERO_BYPASS_EN
   assign w_keep    = w_err;
`else
   assign w_keep    = 1'b1;
`endif
   assign w_store   = w_capture && w_keep;
   assign w_full    = (r_count == c_FULL);
   assign w_pop     = m_tvalid && m_tready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push    = w_store && (!w_full || w_pop);
   assign w_drop    = w_store && w_full && !w_pop;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_frame_cnt <= '0;
         r_overflow  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_synd[i] <= '0;
            r_mem_err[i]  <= 1'b0;
            r_mem_id[i]   <= '0;
         end
      end else begin
         if (w_capture) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_push) begin
            r_mem_synd[r_wr_ptr] <= syndrome_i;
            r_mem_err[r_wr_ptr]  <= w_err;
            r_mem_id[r_wr_ptr]   <= r_frame_cnt;
            r_wr_ptr             <= r_wr_ptr + c_PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_CW'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef RS_SYND_ZERO_BYPASS_EN
   logic [15:0] r_clean_cnt;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_clean_cnt <= '0;
      end else if (w_capture && !w_err) begin
         r_clean_cnt <= r_clean_cnt + 16'd1;
      end
   end

   assign clean_cnt = r_clean_cnt;
`else
   assign clean_cnt = 16'd0;
`endif

   // Outputs come straight from the storage flops at the read pointer.
   assign m_tvalid   = (r_count != '0);
   assign m_syndrome = r_mem_synd[r_rd_ptr];
   assign m_err      = r_mem_err[r_rd_ptr];
   assign m_frame_id = r_mem_id[r_rd_ptr];
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_syndrome_collect
// Brief    : Randomized and directed bench for rs_syndrome_collect against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_collect;

   localparam int ROOTS_NUM  = 16;
   localparam int SYMB_WIDTH = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int W          = ROOTS_NUM * SYMB_WIDTH;

   logic                                 aclk = 1'b0;
   logic                                 aresetn = 1'b0;
   logic                                 s_tvalid = 1'b0;
   logic                                 s_tlast = 1'b0;
   logic                                 m_tready = 1'b0;
   logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syndrome_i = '0;
   logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] m_syndrome;
   logic                                 m_tvalid;
   logic                                 m_err;
   logic [15:0]                          m_frame_id;
   logic                                 overflow;
   logic [15:0]                          clean_cnt;

   rs_syndrome_collect #(
      .ROOTS_NUM  (ROOTS_NUM),
      .SYMB_WIDTH (SYMB_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .syndrome_i (syndrome_i),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_syndrome (m_syndrome),
      .m_err      (m_err),
      .m_frame_id (m_frame_id),
      .overflow   (overflow),
      .clean_cnt  (clean_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [W-1:0] synd;
      logic         err;
      logic [15:0]  id;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mdl_fcnt  = '0;
   logic        mdl_ovf   = 1'b0;
   logic [15:0] mdl_clean = '0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_synd();
      logic [W-1:0] v;
      for (int i = 0; i < ROOTS_NUM; i++) begin
         v[i*SYMB_WIDTH +: SYMB_WIDTH] = SYMB_WIDTH'($urandom);
      end
      return v;
   endfunction

   // Checks current outputs against the model, then drives one cycle of
   // inputs and advances the model to the state after the next rising edge.
   task automatic step(input logic v, input logic l, input logic r, input logic rn,
                       input logic [W-1:0] s);
      bit pop;
      bit full;
      bit keep;
      bit err;
      @(negedge aclk);
      check_value("m_tvalid", W'(m_tvalid), W'(q.size() != 0));
      if (q.size() != 0) begin
         check_value("m_syndrome", m_syndrome, q[0].synd);
         check_value("m_err", W'(m_err), W'(q[0].err));
         check_value("m_frame_id", W'(m_frame_id), W'(q[0].id));
      end
      check_value("overflow", W'(overflow), W'(mdl_ovf));
      check_value("clean_cnt", W'(clean_cnt), W'(mdl_clean));
      s_tvalid   = v;
      s_tlast    = l;
      m_tready   = r;
      aresetn    = rn;
      syndrome_i = s;
      if (!rn) begin
         q.delete();
         mdl_fcnt  = '0;
         mdl_ovf   = 1'b0;
         mdl_clean = '0;
      end else begin
         pop  = r && (q.size() != 0);
         full = (q.size() == FIFO_DEPTH);
         err  = (s != '0);
         keep = 1'b1;
`ifdef RS_SYND_ZERO_BYPASS_EN
         keep = err;
`endif
         if (pop) void'(q.pop_front());
         if (v && l) begin
            if (keep) begin
               if (!full || pop) q.push_back(ent_t'{s, err, mdl_fcnt});
               else mdl_ovf = 1'b1;
            end else begin
               mdl_clean++;
            end
            mdl_fcnt++;
         end
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, rand_synd());
      step(1'b1, 1'b1, 1'b0, 1'b0, rand_synd());
   endtask

   logic [W-1:0] s0;
   logic [15:0]  prev_id;
   logic         prev_v;
   logic         seen_wrap;

   initial begin
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("rst_m_tvalid", W'(m_tvalid), '0);
      check_value("rst_m_syndrome", m_syndrome, '0);
      check_value("rst_m_frame_id", W'(m_frame_id), '0);

      // Single frame with one nonzero root, ready held high.
      s0 = '0;
      s0[3*SYMB_WIDTH +: SYMB_WIDTH] = 8'h5A;
      step(1'b1, 1'b1, 1'b1, 1'b1, s0);
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      check_value("single_tvalid", W'(m_tvalid), W'(1));
      check_value("single_err", W'(m_err), W'(1));
      check_value("single_id", W'(m_frame_id), W'(0));
      check_value("single_synd", m_syndrome, s0);
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      check_value("single_popped", W'(m_tvalid), W'(0));

      // Three back-to-back captures into a depth-2 FIFO with ready low.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("ovf_set", W'(overflow), W'(1));
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      check_value("ovf_head0", W'(m_frame_id), W'(0));
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      check_value("ovf_head1", W'(m_frame_id), W'(1));
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_synd() | W'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("ovf_next_id", W'(m_frame_id), W'(3));

      // Full FIFO, capture coincident with pop.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_synd() | W'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("fullpop_ovf", W'(overflow), W'(0));
      check_value("fullpop_head", W'(m_frame_id), W'(1));
      check_value("fullpop_occ", W'(q.size()), W'(2));

      // All-zero syndrome frame.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
`ifdef RS_SYND_ZERO_BYPASS_EN
      check_value("zero_tvalid", W'(m_tvalid), W'(0));
      check_value("zero_clean", W'(clean_cnt), W'(1));
`else
      check_value("zero_tvalid", W'(m_tvalid), W'(1));
      check_value("zero_err", W'(m_err), W'(0));
`endif

      // Reset while two entries are buffered and overflow is set.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b1, 1'b1, 1'b0, 1'b0, rand_synd() | W'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("midrst_tvalid", W'(m_tvalid), W'(0));
      check_value("midrst_ovf", W'(overflow), W'(0));
      check_value("midrst_synd", m_syndrome, '0);
      check_value("midrst_err", W'(m_err), W'(0));
      check_value("midrst_id", W'(m_frame_id), W'(0));
      step(1'b1, 1'b1, 1'b0, 1'b1, rand_synd() | W'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      check_value("midrst_first_id", W'(m_frame_id), W'(0));

      // Randomized traffic including multi-beat frames and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 2) == 0,
              ($urandom % 100) != 0, (($urandom % 4) == 0) ? '0 : rand_synd());
      end

      // Frame id wrap over a full 16-bit sweep.
      do_reset();
      prev_v    = 1'b0;
      prev_id   = '0;
      seen_wrap = 1'b0;
      for (int n = 0; n < 65540; n++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, rand_synd() | W'(1));
         if (m_tvalid && prev_v && prev_id == 16'hFFFF && m_frame_id == 16'h0000) seen_wrap = 1'b1;
         prev_v  = m_tvalid;
         prev_id = m_frame_id;
      end
      check_value("id_wrap", W'(seen_wrap), W'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_collect.md
RS_SYNDROME_COLLECT -- requirements
Module: rs_syndrome_collect

Interface
REQ-001 SHALL have parameter ROOTS_NUM, default 16, number of syndromes per codeword (2T).
REQ-002 SHALL have parameter SYMB_WIDTH, default 8, GF symbol width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of buffered syndrome sets; power of two, >= 2.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port s_tvalid, input, 1, beat valid, shared with the syndrome calculators.
REQ-007 SHALL have port s_tlast, input, 1, last beat of codeword.
REQ-008 SHALL have port syndrome_i, input, ROOTS_NUM x SYMB_WIDTH, per-root running syndromes; final on the s_tvalid && s_tlast cycle.
REQ-009 SHALL have port m_tvalid, output, 1, syndrome set available.
REQ-010 SHALL have port m_tready, input, 1, downstream key-equation solver accepts.
REQ-011 SHALL have port m_syndrome, output, ROOTS_NUM x SYMB_WIDTH, buffered syndrome set.
REQ-012 SHALL have port m_err, output, 1, high if any symbol of m_syndrome is nonzero.
REQ-013 SHALL have port m_frame_id, output, 16, frame index of the set on m_syndrome.
REQ-014 SHALL have port overflow, output, 1, sticky: a frame was lost because the FIFO was full.
REQ-015 SHALL have port clean_cnt, output, 16, count of error-free frames not forwarded.

Function
REQ-016 Capture event = s_tvalid && s_tlast; no other cycle SHALL write the FIFO.
REQ-017 On capture, SHALL push {syndrome_i, err = OR-reduce(syndrome_i), frame_cnt} when the FIFO is not full.
REQ-018 frame_cnt SHALL increment by 1 on every capture, including dropped frames, and wrap from 0xFFFF to 0x0000.
REQ-019 m_tvalid SHALL equal FIFO non-empty; m_syndrome/m_err/m_frame_id SHALL come from the head entry and be registered (no combinational path from syndrome_i).
REQ-020 Latency: a push into an empty FIFO SHALL raise m_tvalid on the next cycle.
REQ-021 Pop SHALL occur on m_tvalid && m_tready; while m_tvalid && !m_tready, outputs SHALL hold stable.
REQ-022 Simultaneous push and pop when full SHALL accept the push (no drop, no overflow).
REQ-023 Simultaneous push and pop at any occupancy SHALL leave occupancy unchanged.
REQ-024 Push when full without pop SHALL discard the frame and set overflow; it stays set until reset.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use a depth+1 occupancy counter.
REQ-026 Captures on back-to-back cycles SHALL all be handled (single-beat frames).

Reset
REQ-027 While aresetn is low at a clock edge: FIFO empty, m_tvalid=0, m_syndrome=0, m_err=0, m_frame_id=0, frame_cnt=0, overflow=0, clean_cnt=0.
REQ-028 Reset mid-operation SHALL discard all buffered sets; the first capture after release SHALL carry frame id 0.
REQ-029 A capture coincident with active reset SHALL be ignored.

Configuration
REQ-030 Macro RS_SYND_ZERO_BYPASS_EN, when defined, SHALL skip the push of captures whose err = 0, increment clean_cnt instead (wrap at 0xFFFF), and still advance frame_cnt.
REQ-031 Without RS_SYND_ZERO_BYPASS_EN, all captures SHALL be pushed and clean_cnt SHALL be tied to 0.

Verification
REQ-032 Single frame, syndrome_i = all 0x00 except root 3 = 0x5A, m_tready=1 -> m_tvalid one cycle after capture, m_err=1, m_frame_id=0, pop same cycle.
REQ-033 m_tready=0, three captures on consecutive cycles, FIFO_DEPTH=2 -> ids 0,1 buffered, third dropped, overflow=1; releasing ready yields ids 0 then 1; next capture carries id 3.
REQ-034 FIFO full, capture coincident with pop -> no overflow, occupancy stays 2, order preserved.
REQ-035 All-zero syndrome frame: with RS_SYND_ZERO_BYPASS_EN -> no m_tvalid, clean_cnt=1; without -> m_tvalid with m_err=0.
REQ-036 Reset asserted with 2 entries buffered and overflow=1 -> next cycle all outputs 0; post-reset capture gives m_frame_id=0.
REQ-037 0x10000 captures with m_tready=1 -> m_frame_id sequence wraps 0xFFFF -> 0x0000.
